// File: rtl/sync_tx_pkg.sv
// Shared line-symbol constants and FSM encoding for the sync transmitter and
// anything that talks to the sync-detect receiver.
package sync_tx_pkg;

    localparam logic [1:0] SYM_K   = 2'b10;
    localparam logic [1:0] SYM_J   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    localparam int EOP_SE0_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SYNC,
        ST_DATA,
        ST_EOP
    } state_t;

    // Symbol at position idx of the SYNC pattern: KJ pairs, then K, then K
    // (or J when the frame is deliberately corrupted).
    function automatic logic [1:0] sync_sym(input int idx, input int pairs, input logic err);
        if (idx < 2*pairs) return idx[0] ? SYM_J : SYM_K;
        if (idx == 2*pairs) return SYM_K;
        return err ? SYM_J : SYM_K;
    endfunction

endpackage

// File: rtl/sync_tx_nrzi.sv
// NRZI line-level tracker: holds the current K/J level and presents the
// symbol that results from applying bit_in (0 toggles, 1 holds).
module sync_tx_nrzi
    import sync_tx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic       load_lvl,
    input  logic       adv,
    input  logic       bit_in,
    output logic [1:0] sym
);

    logic lvl;   // 1 = K, 0 = J
    logic nxt;

    assign nxt = bit_in ? lvl : ~lvl;
    assign sym = nxt ? SYM_K : SYM_J;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            lvl <= 1'b1;
        else if (load)
            lvl <= load_lvl;
        else if (adv)
            lvl <= nxt;
    end

endmodule

// File: rtl/sync_tx.sv
// Frame transmitter: lead-in J, SYNC (KJ..KJ KK), NRZI payload LSB first,
// EOP (SE0 SE0 J). All line outputs are registered.
module sync_tx
    import sync_tx_pkg::*;
#(
    parameter int IDLE_CYCLES = 2,
    parameter int SYNC_PAIRS  = 3,
    parameter int DATA_BITS   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 err_inject,
    output logic                 tx_k,
    output logic                 tx_j,
    output logic                 tx_en,
    output logic                 ready,
    output logic                 busy,
    output logic                 done
);

    localparam int SYNC_LEN = 2*SYNC_PAIRS + 2;
    localparam int EOP_LEN  = EOP_SE0_CYCLES + 1;
    localparam int M1       = (IDLE_CYCLES > SYNC_LEN) ? IDLE_CYCLES : SYNC_LEN;
    localparam int M2       = (M1 > DATA_BITS) ? M1 : DATA_BITS;
    localparam int CNT_MAX  = (M2 > EOP_LEN) ? M2 : EOP_LEN;
    localparam int CW       = $clog2(CNT_MAX + 1);

    state_t               state;
    logic [CW-1:0]        cnt;      // symbols left in the current state after the one on the line
    logic [DATA_BITS-1:0] data_q;
    logic                 err_q;
    logic                 nrzi_load;
    logic                 nrzi_adv;
    logic [1:0]           nrzi_sym;

    // Reference level is captured as the final SYNC symbol goes out.
    assign nrzi_load = (state == ST_SYNC) && (cnt == CW'(1));
    assign nrzi_adv  = ((state == ST_SYNC) && (cnt == '0)) ||
                       ((state == ST_DATA) && (cnt != '0));

    sync_tx_nrzi u_nrzi (
        .CLK      (CLK),
        .RST      (RST),
        .load     (nrzi_load),
        .load_lvl (~err_q),
        .adv      (nrzi_adv),
        .bit_in   (data_q[0]),
        .sym      (nrzi_sym)
    );

    assign ready = (state == ST_IDLE);
    assign busy  = ~ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            data_q         <= '0;
            err_q          <= 1'b0;
            {tx_k, tx_j}   <= SYM_SE0;
            tx_en          <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        data_q <= data_in;
                        err_q  <= err_inject;
                        tx_en  <= 1'b1;
                        if (IDLE_CYCLES > 0) begin
                            state        <= ST_LEAD;
                            cnt          <= CW'(IDLE_CYCLES - 1);
                            {tx_k, tx_j} <= SYM_J;
                        end else begin
                            state        <= ST_SYNC;
                            cnt          <= CW'(SYNC_LEN - 1);
                            {tx_k, tx_j} <= sync_sym(0, SYNC_PAIRS, err_inject);
                        end
                    end
                end
                ST_LEAD: begin
                    if (cnt == '0) begin
                        state        <= ST_SYNC;
                        cnt          <= CW'(SYNC_LEN - 1);
                        {tx_k, tx_j} <= sync_sym(0, SYNC_PAIRS, err_q);
                    end else begin
                        cnt          <= cnt - 1'b1;
                        {tx_k, tx_j} <= SYM_J;
                    end
                end
                ST_SYNC: begin
                    if (cnt == '0) begin
                        state        <= ST_DATA;
                        cnt          <= CW'(DATA_BITS - 1);
                        {tx_k, tx_j} <= nrzi_sym;
                        data_q       <= data_q >> 1;
                    end else begin
                        cnt          <= cnt - 1'b1;
                        {tx_k, tx_j} <= sync_sym(SYNC_LEN - int'(cnt), SYNC_PAIRS, err_q);
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        state        <= ST_EOP;
                        cnt          <= CW'(EOP_LEN - 1);
                        {tx_k, tx_j} <= SYM_SE0;
                    end else begin
                        cnt          <= cnt - 1'b1;
                        {tx_k, tx_j} <= nrzi_sym;
                        data_q       <= data_q >> 1;
                    end
                end
                ST_EOP: begin
                    if (cnt == '0) begin
                        state        <= ST_IDLE;
                        tx_en        <= 1'b0;
                        {tx_k, tx_j} <= SYM_SE0;
                        done         <= 1'b1;
                    end else begin
                        cnt          <= cnt - 1'b1;
                        {tx_k, tx_j} <= (cnt == CW'(1)) ? SYM_J : SYM_SE0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sync_tx.md
Name: sync_tx

Overview:
Line-side transmitter for the sync-detect receiver under BIST (inputs k, j, rx_en; outputs synced_d, sync_err_d). On a start request it drives a complete frame onto tx_k/tx_j/tx_en: lead-in J, SYNC pattern (KJ…KJ KK), NRZI-coded payload, EOP. Its outputs connect directly to the receiver's k, j, rx_en. An error-inject option corrupts the SYNC pattern so that the receiver's sync_err_d path is exercised.

Parameters:
IDLE_CYCLES, 2, lead-in J symbols before SYNC (0 = none)
SYNC_PAIRS, 3, KJ pairs before the closing KK (>=1); SYNC length = 2*SYNC_PAIRS+2
DATA_BITS, 8, payload bits per frame (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
start  in  1  frame request; sampled only when ready=1
data_in  in  DATA_BITS  payload; latched on the accepting edge
err_inject  in  1  latched on the accepting edge; corrupts the last SYNC symbol
tx_k  out  1  K line
tx_j  out  1  J line
tx_en  out  1  frame-active qualifier (to rx_en)
ready  out  1  1 in IDLE; start accepted
busy  out  1  1 while a frame is in progress
done  out  1  one-cycle pulse at frame end

Behaviour:
- Symbols {tx_k,tx_j}: K=10, J=01, SE0=00. Outputs are registered, with no combinational path from inputs.
- Reset (RST=0, async): tx_k=0, tx_j=0, tx_en=0, busy=0, done=0, ready=1, state=IDLE. Reset mid-frame aborts the frame immediately and does not produce a done pulse.
- FSM states: IDLE -> LEAD -> SYNC -> DATA -> EOP -> IDLE. A down-counter sized for max(IDLE_CYCLES, 2*SYNC_PAIRS+2, DATA_BITS, 3) is reloaded on each state entry.
- IDLE: tx_en=0, lines=00. start=1 at edge E0 latches data_in and err_inject, then enters LEAD (or SYNC if IDLE_CYCLES=0). start while busy is ignored and is not queued.
- LEAD: IDLE_CYCLES cycles of J with tx_en=1.
- SYNC: symbols K,J repeated SYNC_PAIRS times, then K,K. If err_inject was latched, the final symbol is J instead of K.
- DATA: DATA_BITS cycles, LSB first, NRZI encoded. Bit 0 toggles the line between K and J; bit 1 holds it. The reference level is the last SYNC symbol actually driven (J when corrupted). There is no bit stuffing.
- EOP: 2 cycles SE0 followed by 1 cycle J, all with tx_en=1.
- Timing: the first frame symbol is visible in the cycle after E0. The frame lasts N = IDLE_CYCLES + 2*SYNC_PAIRS+2 + DATA_BITS + 3 cycles, with tx_en=1 and busy=1 throughout.
  - At edge E0+N: tx_en=0, lines=00, busy=0, ready=1, done=1 for exactly one cycle.
  - start seen high in that done cycle is accepted, so frames run back-to-back with a 1-cycle gap.
- ready = (state==IDLE). busy = !ready.

Decomposition:
- Shared package sync_tx_pkg:
  - symbol constants SYM_K, SYM_J, SYM_SE0
  - FSM state encoding
  - EOP_SE0_CYCLES=2
  The receiver-side testbench and the BIST checker reuse the symbol constants.
- One natural sub-module: sync_tx_nrzi. It holds a 1-bit line-level register with load (from the SYNC end) and bit-in/advance inputs, and outputs the current K/J symbol.

Test Plan:
- Reset: drive RST=0 mid-DATA, then release -> outputs immediately 00/tx_en=0/ready=1, no done pulse; the next start produces a full frame.
- Default parameters, data_in=8'hA5, err_inject=0 -> J J, K J K J K J K K, K J J K J J K K, SE0 SE0 J. N=21, done asserted at E0+21; the receiver reports synced_d=1, sync_err_d=0.
- data_in=8'h00 -> payload J K J K J K J K. data_in=8'hFF -> payload K×8.
- err_inject=1, data_in=8'hA5 -> SYNC ends K J. The payload is referenced to J: J K K J K K J J. The receiver asserts sync_err_d.
- start held high continuously -> frames separated by exactly one idle cycle (tx_en=0). start pulses during busy are ignored (frame count unchanged).
- IDLE_CYCLES=0, SYNC_PAIRS=1, DATA_BITS=1, data_in=1 -> K J K K, K, SE0 SE0 J, N=8.
